// File: rtl/data_type_pkg.sv
// Shared data types and constants for the arithmetic units behind op_intf.
package data_type_pkg;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned MODE_WIDTH = 2;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;
    localparam int unsigned EXP_BIAS  = 127;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        NORM,
        DONE
    } mul_state_e;

    typedef enum logic [1:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_INF,
        CLS_NAN
    } op_class_e;

endpackage

// File: rtl/op_intf.sv
// Operand/result bundle between the operation mux (bus side) and an arithmetic unit.
interface op_intf #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 7
);
    logic                  op1_sign;
    logic [EXP_WIDTH-1:0]  op1_exp;
    logic [FRAC_WIDTH-1:0] op1_frac;
    logic                  op2_sign;
    logic [EXP_WIDTH-1:0]  op2_exp;
    logic [FRAC_WIDTH-1:0] op2_frac;
    logic                  op3_sign;
    logic [EXP_WIDTH-1:0]  op3_exp;
    logic [FRAC_WIDTH-1:0] op3_frac;
    logic                  overflow;

    modport bus_side (
        output op1_sign, op1_exp, op1_frac,
        output op2_sign, op2_exp, op2_frac,
        input  op3_sign, op3_exp, op3_frac, overflow
    );

    modport unit_side (
        input  op1_sign, op1_exp, op1_frac,
        input  op2_sign, op2_exp, op2_frac,
        output op3_sign, op3_exp, op3_frac, overflow
    );
endinterface

// File: rtl/mant_shift_add.sv
// Iterative mantissa multiplier: one shift-add step per cycle over the multiplier bits.
module mant_shift_add #(
    parameter int unsigned MANT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [MANT_WIDTH-1:0] mcand,
    input  logic [MANT_WIDTH-1:0] mplier,
    output logic [MANT_WIDTH:0]   prod_top,
    output logic                  done
);
    localparam int unsigned PROD_WIDTH = 2 * MANT_WIDTH;
    localparam int unsigned CNT_WIDTH  = $clog2(MANT_WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MANT_WIDTH - 1);

    logic [MANT_WIDTH-1:0] mcand_q;
    logic [MANT_WIDTH-1:0] mplier_q;
    logic [PROD_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
        end else if (start) begin
            mcand_q  <= mcand;
            mplier_q <= mplier;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (mplier_q[cnt]) begin
                acc <= acc + ({{MANT_WIDTH{1'b0}}, mcand_q} << cnt);
            end
            if (cnt == CNT_LAST) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only the bits normalization can select are exported; truncation discards the rest.
    assign prod_top = acc[PROD_WIDTH-1 -: MANT_WIDTH+1];
    assign done     = busy && (cnt == CNT_LAST);

endmodule

// File: rtl/bf16_mul_seq.sv
// Sequential bfloat16 multiplier: handshake in, shift-add mantissa product,
// normalize/classify, hold the result until the consumer takes it.
module bf16_mul_seq
    import data_type_pkg::*;
#(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned FRAC_WIDTH = 7
) (
    input  logic     clk,
    input  logic     rst,
    op_intf.unit_side op,
    input  logic     in_valid_i,
    output logic     in_ready_o,
    output logic     out_valid_o,
    input  logic     out_ready_i
);
    localparam int unsigned MANT_WIDTH = FRAC_WIDTH + 1;
    localparam int unsigned EW         = EXP_WIDTH + 2;
    localparam logic [EW-1:0] E_BIAS   = EW'((1 << (EXP_WIDTH - 1)) - 1);
    localparam logic [EW-1:0] E_ONES   = EW'((1 << EXP_WIDTH) - 1);

    function automatic op_class_e classify(input logic [EXP_WIDTH-1:0] e,
                                           input logic [FRAC_WIDTH-1:0] f);
        if (e == '0) return CLS_ZERO;
        if (e == '1) return (f == '0) ? CLS_INF : CLS_NAN;
        return CLS_NORMAL;
    endfunction

    mul_state_e state, state_nxt;

    logic                  start;
    logic                  mul_done;
    logic [MANT_WIDTH:0]   prod_top;

    logic                  sign_q;
    logic [EXP_WIDTH-1:0]  exp1_q, exp2_q;
    op_class_e             cls1_q, cls2_q;

    logic                  res_sign_q, res_sign_d;
    logic [EXP_WIDTH-1:0]  res_exp_q, res_exp_d;
    logic [FRAC_WIDTH-1:0] res_frac_q, res_frac_d;
    logic                  ovf_q, ovf_d;

    logic signed [EW-1:0]  e_sum;
    logic [FRAC_WIDTH-1:0] frac_n;
    logic                  any_nan, any_inf, any_zero;

    assign start = (state == IDLE) && in_valid_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) state_nxt = MUL;
            end
            MUL:  if (mul_done) state_nxt = NORM;
            NORM: state_nxt = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q <= 1'b0;
            exp1_q <= '0;
            exp2_q <= '0;
            cls1_q <= CLS_NORMAL;
            cls2_q <= CLS_NORMAL;
        end else if (start) begin
            sign_q <= op.op1_sign ^ op.op2_sign;
            exp1_q <= op.op1_exp;
            exp2_q <= op.op2_exp;
            cls1_q <= classify(op.op1_exp, op.op1_frac);
            cls2_q <= classify(op.op2_exp, op.op2_frac);
        end
    end

    mant_shift_add #(
        .MANT_WIDTH(MANT_WIDTH)
    ) u_mant (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mcand   ({op.op1_exp != '0, op.op1_frac}),
        .mplier  ({op.op2_exp != '0, op.op2_frac}),
        .prod_top(prod_top),
        .done    (mul_done)
    );

    always_comb begin
        e_sum = $signed({2'b00, exp1_q}) + $signed({2'b00, exp2_q}) - $signed(E_BIAS)
              + $signed({{(EW-1){1'b0}}, prod_top[MANT_WIDTH]});
        frac_n = prod_top[MANT_WIDTH] ? prod_top[MANT_WIDTH-1 -: FRAC_WIDTH]
                                      : prod_top[FRAC_WIDTH-1:0];
        any_nan  = (cls1_q == CLS_NAN)  || (cls2_q == CLS_NAN);
        any_inf  = (cls1_q == CLS_INF)  || (cls2_q == CLS_INF);
        any_zero = (cls1_q == CLS_ZERO) || (cls2_q == CLS_ZERO);

        res_sign_d = sign_q;
        res_exp_d  = e_sum[EXP_WIDTH-1:0];
        res_frac_d = frac_n;
        ovf_d      = 1'b0;

        if (any_nan || (any_inf && any_zero)) begin
            res_sign_d = 1'b0;
            res_exp_d  = '1;
            res_frac_d = {1'b1, {(FRAC_WIDTH-1){1'b0}}};
        end else if (any_inf) begin
            res_exp_d  = '1;
            res_frac_d = '0;
        end else if (any_zero) begin
            res_exp_d  = '0;
            res_frac_d = '0;
        end else if (e_sum >= $signed(E_ONES)) begin
            res_exp_d  = '1;
            res_frac_d = '0;
            ovf_d      = 1'b1;
        end else if (e_sum[EW-1] || (e_sum == '0)) begin
            res_exp_d  = '0;
            res_frac_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_sign_q <= 1'b0;
            res_exp_q  <= '0;
            res_frac_q <= '0;
            ovf_q      <= 1'b0;
        end else if (state == NORM) begin
            res_sign_q <= res_sign_d;
            res_exp_q  <= res_exp_d;
            res_frac_q <= res_frac_d;
            ovf_q      <= ovf_d;
        end
    end

    assign op.op3_sign = res_sign_q;
    assign op.op3_exp  = res_exp_q;
    assign op.op3_frac = res_frac_q;
    assign op.overflow = ovf_q;

endmodule
